bus_sequencer: RTL

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/bus_sequencer.sv
// Host-bus command sequencer: synchronised strobe capture into a small FIFO, then in-order execution.
// Capture 3 edges after strobe rise, pop 1 cycle later; engine-busy stalls writes/START, a full FIFO drops words.
module bus_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [23:0]       bus_ext,
    output logic [23:0]       host_bus,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              eng_start,
    output logic              eng_rst,
    input  logic              eng_busy,
    input  logic              eng_done,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [15:0]       res_rdata,
    output logic [2:0]        fifo_count,
    output logic              err_ovf,
    output logic              err_op
);
    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WR_W  = 3'd1;
    localparam logic [2:0] OP_WR_P  = 3'd2;
    localparam logic [2:0] OP_START = 3'd3;
    localparam logic [2:0] OP_RD    = 3'd4;
    localparam logic [2:0] OP_SRST  = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WAIT_ENG, S_READ_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic        r_sync1, r_sync2, r_edge, r_armed;
    logic [1:0]  r_warm;
    logic [22:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [2:0]  r_count;
    logic [22:0] r_cmd;
    logic [15:0] r_rdata;
    logic [23:0] r_host;
    logic        r_err_ovf, r_err_op;
    logic        w_cap, w_full, w_empty, w_push, w_pop, w_flush, w_set_op;
    logic [2:0]  w_op;

    // r_armed only sets once the synchronizer holds a real sample of a low strobe,
    // so a strobe already high when reset releases is never taken as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
            r_warm  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= bus_ext[23];
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
            r_warm  <= {r_warm[0], 1'b1};
            if (r_warm[1] && !r_sync2)
                r_armed <= 1'b1;
        end
    end

    assign w_cap   = r_sync2 & ~r_edge & r_armed;
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == 3'd0);
    assign w_push  = w_cap & ~w_full & ~w_flush;
    assign w_op    = r_cmd[22:20];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= bus_ext[22:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 3'd0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 3'd0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_ovf <= 1'b0;
            r_err_op  <= 1'b0;
        end else if (w_flush) begin
            r_err_ovf <= 1'b0;
            r_err_op  <= 1'b0;
        end else begin
            if (w_cap && w_full)
                r_err_ovf <= 1'b1;
            if (w_set_op)
                r_err_op <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cmd   <= '0;
            r_rdata <= '0;
            r_host  <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop)
                r_cmd <= r_mem[r_rptr];
            if (r_state == S_READ_WAIT)
                r_rdata <= res_rdata;
            if (r_state == S_RESP)
                r_host <= {~r_host[23], OP_RD, 4'd0, r_rdata};
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_flush   = 1'b0;
        w_set_op  = 1'b0;
        mem_we    = 1'b0;
        eng_start = 1'b0;
        eng_rst   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_op)
                    OP_NOP: w_next = S_IDLE;
                    OP_WR_W, OP_WR_P: begin
                        if (!eng_busy) begin
                            mem_we = 1'b1;
                            w_next = S_IDLE;
                        end
                    end
                    OP_START: begin
                        if (!eng_busy) begin
                            eng_start = 1'b1;
                            w_next    = S_WAIT_ENG;
                        end
                    end
                    OP_RD:  w_next = S_READ_WAIT;
                    OP_SRST: begin
                        eng_rst = 1'b1;
                        w_flush = 1'b1;
                        w_next  = S_IDLE;
                    end
                    default: begin
                        w_set_op = 1'b1;
                        w_next   = S_IDLE;
                    end
                endcase
            end
            S_WAIT_ENG:  if (eng_done) w_next = S_IDLE;
            S_READ_WAIT: w_next = S_RESP;
            S_RESP:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    assign mem_sel    = (w_op == OP_WR_P);
    assign mem_addr   = ADDR_W'(r_cmd[19:8]);
    assign mem_wdata  = r_cmd[7:0];
    assign res_addr   = ADDR_W'(r_cmd[19:8]);
    assign host_bus   = r_host;
    assign fifo_count = r_count;
    assign err_ovf    = r_err_ovf;
    assign err_op     = r_err_op;
endmodule
